mem_2p: RTL and testbench

Parametrised true-dual-port successor to the single-port byte-strobed memory. Two independent request ports share one storage array, each with req/gnt handshake, configurable read latency and per-request response. After reset the block zero-fills the array in hardware before granting any request. It sits between the core/DMA interconnect and on-chip storage wherever two masters need concurrent access.

---
 rtl/mem_2p.sv | 162 ++++++++++++++++
 tb/tb_mem_2p.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_2p.sv
// True-dual-port word memory with byte strobes, req/gnt handshake per port and
// a fixed-latency response pipeline; zero-fills itself after reset.
module mem_2p #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    init_busy_o,

    input  logic                    pa_req_i,
    input  logic                    pa_we_i,
    input  logic [ADDR_WIDTH-1:0]   pa_addr_i,
    input  logic [DATA_WIDTH-1:0]   pa_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] pa_wstrb_i,
    output logic                    pa_gnt_o,
    output logic                    pa_rvalid_o,
    output logic [DATA_WIDTH-1:0]   pa_rdata_o,
    output logic                    pa_err_o,

    input  logic                    pb_req_i,
    input  logic                    pb_we_i,
    input  logic [ADDR_WIDTH-1:0]   pb_addr_i,
    input  logic [DATA_WIDTH-1:0]   pb_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] pb_wstrb_i,
    output logic                    pb_gnt_o,
    output logic                    pb_rvalid_o,
    output logic [DATA_WIDTH-1:0]   pb_rdata_o,
    output logic                    pb_err_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] sweep_cnt, sweep_cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            req, we, acc, in_range;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [STRB_W-1:0]     wstrb [2];
    logic [IDX_W-1:0]      idx   [2];
    logic                  rvalid [2];
    logic                  rerr   [2];
    logic [DATA_WIDTH-1:0] rdata  [2];

    assign req      = {pb_req_i, pa_req_i};
    assign we       = {pb_we_i, pa_we_i};
    assign addr[0]  = pa_addr_i;
    assign addr[1]  = pb_addr_i;
    assign wdata[0] = pa_wdata_i;
    assign wdata[1] = pb_wdata_i;
    assign wstrb[0] = pa_wstrb_i;
    assign wstrb[1] = pb_wstrb_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        if (state == INIT) begin
            sweep_cnt_next = sweep_cnt + 1'b1;
            if (sweep_cnt == LAST_IDX) begin
                state_next     = RUN;
                sweep_cnt_next = '0;
            end
        end
    end

    // Reset itself counts as busy so nothing is granted while it is held.
    assign init_busy_o = rst_i | (state == INIT);

    always_comb begin
        acc      = '0;
        in_range = '0;
        for (int p = 0; p < 2; p++) begin
            acc[p]      = req[p] & ~init_busy_o;
            in_range[p] = ({1'b0, addr[p]} < DEPTH_CMP);
            idx[p]      = addr[p][IDX_W-1:0];
        end
    end

    assign pa_gnt_o = acc[0];
    assign pb_gnt_o = acc[1];

    // Port B is applied first so that port A's strobed bytes overwrite it on a collision.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == INIT) begin
            mem[sweep_cnt] <= '0;
        end
        for (int p = 1; p >= 0; p--) begin
            if (acc[p] && we[p] && in_range[p]) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[p][b]) begin
                        mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [RD_LATENCY-1:0] stg_vld;
        logic [RD_LATENCY-1:0] stg_err;
        logic [DATA_WIDTH-1:0] stg_dat [RD_LATENCY];

        // Data/err stages only load behind a valid entry, so the outputs hold between responses.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stg_vld <= '0;
                stg_err <= '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    stg_dat[i] <= '0;
                end
            end else begin
                stg_vld[0] <= acc[p];
                if (acc[p]) begin
                    stg_err[0] <= ~in_range[p];
                    stg_dat[0] <= (!we[p] && in_range[p]) ? mem[idx[p]] : '0;
                end
                for (int i = 1; i < RD_LATENCY; i++) begin
                    stg_vld[i] <= stg_vld[i-1];
                    if (stg_vld[i-1]) begin
                        stg_err[i] <= stg_err[i-1];
                        stg_dat[i] <= stg_dat[i-1];
                    end
                end
            end
        end

        assign rvalid[p] = stg_vld[RD_LATENCY-1];
        assign rerr[p]   = stg_err[RD_LATENCY-1];
        assign rdata[p]  = stg_dat[RD_LATENCY-1];
    end

    assign pa_rvalid_o = rvalid[0];
    assign pa_err_o    = rerr[0];
    assign pa_rdata_o  = rdata[0];
    assign pb_rvalid_o = rvalid[1];
    assign pb_err_o    = rerr[1];
    assign pb_rdata_o  = rdata[1];

endmodule

// File: tb/tb_mem_2p.sv
// Directed bench for mem_2p with DEPTH=16 and RD_LATENCY=2; expected values
// are hand-computed constants checked with immediate assertions.
module tb_mem_2p;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          init_busy_o;
    logic          pa_req_i, pa_we_i, pb_req_i, pb_we_i;
    logic [AW-1:0] pa_addr_i, pb_addr_i;
    logic [DW-1:0] pa_wdata_i, pb_wdata_i;
    logic [3:0]    pa_wstrb_i, pb_wstrb_i;
    logic          pa_gnt_o, pa_rvalid_o, pa_err_o;
    logic          pb_gnt_o, pb_rvalid_o, pb_err_o;
    logic [DW-1:0] pa_rdata_o, pb_rdata_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_2p #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .RD_LATENCY(LAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .init_busy_o(init_busy_o),
        .pa_req_i(pa_req_i),
        .pa_we_i(pa_we_i),
        .pa_addr_i(pa_addr_i),
        .pa_wdata_i(pa_wdata_i),
        .pa_wstrb_i(pa_wstrb_i),
        .pa_gnt_o(pa_gnt_o),
        .pa_rvalid_o(pa_rvalid_o),
        .pa_rdata_o(pa_rdata_o),
        .pa_err_o(pa_err_o),
        .pb_req_i(pb_req_i),
        .pb_we_i(pb_we_i),
        .pb_addr_i(pb_addr_i),
        .pb_wdata_i(pb_wdata_i),
        .pb_wstrb_i(pb_wstrb_i),
        .pb_gnt_o(pb_gnt_o),
        .pb_rvalid_o(pb_rvalid_o),
        .pb_rdata_o(pb_rdata_o),
        .pb_err_o(pb_err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] observed,
                                input logic [DW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit port_b, input bit req, input bit we,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                  input logic [3:0] wstrb);
        if (!port_b) begin
            pa_req_i = req; pa_we_i = we; pa_addr_i = addr; pa_wdata_i = wdata; pa_wstrb_i = wstrb;
        end else begin
            pb_req_i = req; pb_we_i = we; pb_addr_i = addr; pb_wdata_i = wdata; pb_wstrb_i = wstrb;
        end
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Counts busy cycles (bounded) while both ports request, noting any grant or response.
    task automatic count_busy(output int cycles, output bit saw_gnt, output bit saw_rvalid);
        cycles     = 0;
        saw_gnt    = 1'b0;
        saw_rvalid = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd0, '0, '0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5'd0, '0, '0);
        while (init_busy_o === 1'b1 && cycles < 40) begin
            if (pa_gnt_o !== 1'b0 || pb_gnt_o !== 1'b0) saw_gnt = 1'b1;
            if (pa_rvalid_o !== 1'b0 || pb_rvalid_o !== 1'b0) saw_rvalid = 1'b1;
            cycles++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busy_cycles;
        bit saw_gnt, saw_rvalid;
        logic [DW-1:0] exp_a, exp_b;

        rst_i = 1'b1;
        idle();
        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd0, '0, '0);
        #1;
        check_output("busy_during_reset", init_busy_o, 1'b1);
        check_output("no_gnt_during_reset", pa_gnt_o, 1'b0);
        tick();
        tick();
        check_output("reset_busy", init_busy_o, 1'b1);
        check_output("reset_gnt_a", pa_gnt_o, 1'b0);
        check_output("reset_rvalid_a", pa_rvalid_o, 1'b0);
        check_output("reset_rvalid_b", pb_rvalid_o, 1'b0);
        check_output("reset_rdata_a", pa_rdata_o, '0);
        check_output("reset_err_a", pa_err_o, 1'b0);

        rst_i = 1'b0;
        count_busy(busy_cycles, saw_gnt, saw_rvalid);
        check_output("sweep_busy_cycles", busy_cycles, DEPTH);
        check_output("sweep_no_gnt", saw_gnt, 1'b0);
        check_output("sweep_no_rvalid", saw_rvalid, 1'b0);
        check_output("gnt_after_sweep", pa_gnt_o, 1'b1);
        idle();

        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) apply_stimulus(1'b0, 1'b1, 1'b0, AW'(i), '0, '0);
            else idle();
            tick();
            if (i >= 1) begin
                check_output($sformatf("zero_rvalid_%0d", i - 1), pa_rvalid_o, 1'b1);
                check_output($sformatf("zero_rdata_%0d", i - 1), pa_rdata_o, '0);
            end
        end
        tick();
        check_output("zero_rvalid_done", pa_rvalid_o, 1'b0);

        apply_stimulus(1'b0, 1'b1, 1'b1, 5'd5, 32'h11223344, 4'b1111);
        #1;
        check_output("strb_gnt", pa_gnt_o, 1'b1);
        tick();
        check_output("strb_lat_not_yet", pa_rvalid_o, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 5'd5, 32'hAABBCCDD, 4'b0101);
        tick();
        check_output("strb_wr1_rvalid", pa_rvalid_o, 1'b1);
        check_output("strb_wr1_rdata", pa_rdata_o, '0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd5, '0, '0);
        tick();
        check_output("strb_wr2_rvalid", pa_rvalid_o, 1'b1);
        idle();
        tick();
        check_output("strb_rd_rvalid", pa_rvalid_o, 1'b1);
        check_output("strb_rd_rdata", pa_rdata_o, 32'h11BB33DD);
        tick();
        check_output("strb_idle_rvalid", pa_rvalid_o, 1'b0);
        check_output("strb_hold_rdata", pa_rdata_o, 32'h11BB33DD);

        apply_stimulus(1'b0, 1'b1, 1'b1, 5'd3, 32'hFFFF0000, 4'b1100);
        apply_stimulus(1'b1, 1'b1, 1'b1, 5'd3, 32'h12345678, 4'b1111);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd3, '0, '0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        tick();
        check_output("coll_b_wr_rvalid", pb_rvalid_o, 1'b1);
        check_output("coll_b_wr_rdata", pb_rdata_o, '0);
        idle();
        tick();
        check_output("coll_rd_rdata", pa_rdata_o, 32'hFFFF5678);

        apply_stimulus(1'b0, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 4'b1111);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5'd7, '0, '0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        check_output("rf_old_rvalid", pb_rvalid_o, 1'b1);
        check_output("rf_old_rdata", pb_rdata_o, '0);
        idle();
        tick();
        check_output("rf_new_rvalid", pb_rvalid_o, 1'b1);
        check_output("rf_new_rdata", pb_rdata_o, 32'hDEADBEEF);

        // Even steps write, odd steps read back the word written on the previous edge.
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                apply_stimulus(1'b0, 1'b1, (j % 2) == 0, AW'(8 + j / 2), 32'hA0000000 + j, 4'b1111);
                apply_stimulus(1'b1, 1'b1, (j % 2) == 0, AW'(12 + j / 2), 32'hB0000000 + j, 4'b1111);
            end else begin
                idle();
            end
            tick();
            if (j >= 1) begin
                exp_a = ((j - 1) % 2 == 1) ? 32'hA0000000 + (j - 2) : 32'h0;
                exp_b = ((j - 1) % 2 == 1) ? 32'hB0000000 + (j - 2) : 32'h0;
                check_output($sformatf("b2b_a_rvalid_%0d", j - 1), pa_rvalid_o, 1'b1);
                check_output($sformatf("b2b_a_rdata_%0d", j - 1), pa_rdata_o, exp_a);
                check_output($sformatf("b2b_a_err_%0d", j - 1), pa_err_o, 1'b0);
                check_output($sformatf("b2b_b_rvalid_%0d", j - 1), pb_rvalid_o, 1'b1);
                check_output($sformatf("b2b_b_rdata_%0d", j - 1), pb_rdata_o, exp_b);
            end
        end
        tick();
        check_output("b2b_a_done", pa_rvalid_o, 1'b0);
        check_output("b2b_b_done", pb_rvalid_o, 1'b0);

        apply_stimulus(1'b0, 1'b1, 1'b0, AW'(DEPTH), '0, '0);
        apply_stimulus(1'b1, 1'b1, 1'b1, AW'(DEPTH), 32'hFFFFFFFF, 4'b1111);
        tick();
        idle();
        tick();
        check_output("err_rd_rvalid", pa_rvalid_o, 1'b1);
        check_output("err_rd_err", pa_err_o, 1'b1);
        check_output("err_rd_rdata", pa_rdata_o, '0);
        check_output("err_wr_rvalid", pb_rvalid_o, 1'b1);
        check_output("err_wr_err", pb_err_o, 1'b1);
        check_output("err_wr_rdata", pb_rdata_o, '0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd0, '0, '0);
        tick();
        idle();
        tick();
        check_output("err_alias_rdata", pa_rdata_o, '0);
        check_output("err_alias_err", pa_err_o, 1'b0);

        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd5, '0, '0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5'd3, '0, '0);
        tick();
        rst_i = 1'b1;
        idle();
        tick();
        check_output("rst_drop_a", pa_rvalid_o, 1'b0);
        check_output("rst_drop_b", pb_rvalid_o, 1'b0);
        tick();
        check_output("rst_drop_a2", pa_rvalid_o, 1'b0);
        check_output("rst_busy", init_busy_o, 1'b1);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_output("midsweep_busy", init_busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        count_busy(busy_cycles, saw_gnt, saw_rvalid);
        check_output("resweep_busy_cycles", busy_cycles, DEPTH);
        check_output("resweep_no_gnt", saw_gnt, 1'b0);
        check_output("resweep_no_rvalid", saw_rvalid, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 5'd15, '0, '0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5'd9, '0, '0);
        tick();
        idle();
        tick();
        check_output("resweep_rd15_rvalid", pa_rvalid_o, 1'b1);
        check_output("resweep_rd15_rdata", pa_rdata_o, '0);
        check_output("resweep_rd9_rdata", pb_rdata_o, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
